// File: rtl/f_stream_packer.sv
// Packs RATIO narrow AXI-Stream beats into one wide word behind a one-word output register.
// Short frames are zero-padded; the first word of a frame can carry a weight-set switch tag.
module f_stream_packer #(
  parameter int IN_W  = 512,
  parameter int RATIO = 3,
  parameter int CNT_W = 16,
  localparam int OUT_W = IN_W * RATIO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic             weight_switch_req,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             weight_switch,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_partial
);

  localparam int BC_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(RATIO - 1);

  logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [OUT_W-1:0] asm_q, asm_d;
  logic [OUT_W-1:0] word_asm;
  logic             tvalid_q, tvalid_d;
  logic [OUT_W-1:0] tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic             wsw_q, wsw_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             err_q, err_d;
  logic             pending_q, pending_d;
  logic             frame_start_q, frame_start_d;

  logic out_free;
  logic beat_acc;
  logic word_done;
  logic out_hs;

  // A beat that would complete the word may only enter when the output register can take it.
  assign out_free      = !tvalid_q | m_axis_tready;
  assign s_axis_tready = out_free | ((beat_cnt_q < LAST_BEAT) & !s_axis_tlast);
  assign beat_acc      = s_axis_tvalid & s_axis_tready;
  assign word_done     = beat_acc & ((beat_cnt_q == LAST_BEAT) | s_axis_tlast);
  assign out_hs        = tvalid_q & m_axis_tready;

  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
      assign word_asm[gi*IN_W +: IN_W] =
          (beat_cnt_q == BC_W'(gi)) ? s_axis_tdata :
          (beat_cnt_q >  BC_W'(gi)) ? asm_q[gi*IN_W +: IN_W] : '0;
      assign asm_d[gi*IN_W +: IN_W] =
          (beat_acc && beat_cnt_q == BC_W'(gi)) ? s_axis_tdata : asm_q[gi*IN_W +: IN_W];
    end
  endgenerate

  always_comb begin
    beat_cnt_d    = beat_cnt_q;
    tvalid_d      = tvalid_q;
    tdata_d       = tdata_q;
    tlast_d       = tlast_q;
    wsw_d         = wsw_q;
    frame_cnt_d   = frame_cnt_q;
    err_d         = err_q;
    pending_d     = pending_q | weight_switch_req;
    frame_start_d = frame_start_q;

    if (out_hs) begin
      tvalid_d = 1'b0;
      if (tlast_q) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end

    if (beat_acc) beat_cnt_d = beat_cnt_q + BC_W'(1);

    if (word_done) begin
      beat_cnt_d    = '0;
      tvalid_d      = 1'b1;
      tdata_d       = word_asm;
      tlast_d       = s_axis_tlast;
      frame_start_d = s_axis_tlast;
      if (beat_cnt_q != LAST_BEAT) err_d = 1'b1;
      // A request coinciding with the tagged load is kept for the next frame.
      if (frame_start_q) begin
        wsw_d     = pending_q | weight_switch_req;
        pending_d = weight_switch_req;
      end else begin
        wsw_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q    <= '0;
      asm_q         <= '0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      tlast_q       <= 1'b0;
      wsw_q         <= 1'b0;
      frame_cnt_q   <= '0;
      err_q         <= 1'b0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b1;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      asm_q         <= asm_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      tlast_q       <= tlast_d;
      wsw_q         <= wsw_d;
      frame_cnt_q   <= frame_cnt_d;
      err_q         <= err_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign weight_switch = wsw_q;
  assign frame_cnt     = frame_cnt_q;
  assign err_partial   = err_q;

endmodule

// File: tb/tb_f_stream_packer.sv
// Bench for f_stream_packer: directed scenarios with literal expectations plus a random
// run, all cross-checked every cycle against a queue-based behavioural model.
module tb_f_stream_packer;

  localparam int IN_W  = 512;
  localparam int RATIO = 3;
  localparam int CNT_W = 4;
  localparam int OUT_W = IN_W * RATIO;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IN_W-1:0]  s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic             weight_switch_req;
  logic [OUT_W-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic             weight_switch;
  logic [CNT_W-1:0] frame_cnt;
  logic             err_partial;

  always #5 clk = ~clk;

  f_stream_packer #(.IN_W(IN_W), .RATIO(RATIO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .weight_switch_req(weight_switch_req),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .weight_switch(weight_switch), .frame_cnt(frame_cnt), .err_partial(err_partial)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: beats collected in a queue, one held output word.
  bit               mv, mlast, mws, merr, mpend, mfs;
  logic [OUT_W-1:0] mdata;
  int unsigned      mfcnt;
  logic [IN_W-1:0]  mbuf[$];
  bit               acc_flag;

  typedef struct {
    logic [OUT_W-1:0] d;
    bit               l;
    bit               w;
  } word_t;
  word_t obs[$];

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_word(string nm, logic [OUT_W-1:0] got, logic [OUT_W-1:0] exp);
    int s;
    n_chk++;
    if (got !== exp) begin
      s = 0;
      for (int i = RATIO - 1; i >= 0; i--)
        if (got[IN_W*i +: IN_W] !== exp[IN_W*i +: IN_W]) s = i;
      n_fail++;
      $display("FAIL %s: slice %0d got %0h expected %0h", nm, s,
               got[IN_W*s +: IN_W], exp[IN_W*s +: IN_W]);
    end
  endtask

  function automatic logic [OUT_W-1:0] w3(logic [IN_W-1:0] a, logic [IN_W-1:0] b,
                                          logic [IN_W-1:0] c);
    return {c, b, a};
  endfunction

  function automatic bit exp_rdy();
    return !mv || m_axis_tready || (mbuf.size() < RATIO - 1 && !s_axis_tlast);
  endfunction

  task automatic model_reset();
    mv = 0; mdata = '0; mlast = 0; mws = 0; merr = 0; mpend = 0; mfs = 1; mfcnt = 0;
    mbuf.delete();
    acc_flag = 0;
  endtask

  task automatic model_step();
    bit rdy, acc, hs, ld;
    if (!rst_n) begin
      model_reset();
    end else begin
      rdy = exp_rdy();
      acc = s_axis_tvalid && rdy;
      hs  = mv && m_axis_tready;
      acc_flag = acc;
      if (hs) begin
        if (mlast) mfcnt = (mfcnt + 1) % (1 << CNT_W);
        mv = 0;
      end
      ld = acc && (mbuf.size() == RATIO - 1 || s_axis_tlast);
      if (acc) mbuf.push_back(s_axis_tdata);
      if (ld) begin
        mdata = '0;
        foreach (mbuf[i]) mdata |= OUT_W'(mbuf[i]) << (IN_W * i);
        mv = 1;
        mlast = s_axis_tlast;
        if (mbuf.size() < RATIO) merr = 1;
        if (mfs) begin
          mws   = mpend || weight_switch_req;
          mpend = weight_switch_req;
        end else begin
          mws   = 0;
          mpend = mpend || weight_switch_req;
        end
        mfs = s_axis_tlast;
        mbuf.delete();
      end else begin
        mpend = mpend || weight_switch_req;
      end
    end
  endtask

  task automatic compare();
    word_t w;
    chk("tvalid", 64'(m_axis_tvalid), 64'(mv));
    chk("frame_cnt", 64'(frame_cnt), 64'(mfcnt));
    chk("err_partial", 64'(err_partial), 64'(merr));
    chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy()));
    if (mv) begin
      chk_word("tdata", m_axis_tdata, mdata);
      chk("tlast", 64'(m_axis_tlast), 64'(mlast));
      chk("weight_switch", 64'(weight_switch), 64'(mws));
    end
    if (m_axis_tvalid && m_axis_tready) begin
      w.d = m_axis_tdata; w.l = m_axis_tlast; w.w = weight_switch;
      obs.push_back(w);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; s_axis_tvalid = 0; weight_switch_req = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic idle(int n);
    s_axis_tvalid = 0; weight_switch_req = 0;
    repeat (n) tick();
  endtask

  task automatic send_beat(logic [IN_W-1:0] d, bit l, bit rq);
    bit done;
    done = 0;
    s_axis_tvalid = 1; s_axis_tdata = d; s_axis_tlast = l; weight_switch_req = rq;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      weight_switch_req = 0;
      if (acc_flag) done = 1;
    end
    if (!done) chk("beat_timeout", 64'(0), 64'(1));
  endtask

  task automatic chk_obs(int idx, logic [OUT_W-1:0] d, bit l, bit w);
    if (idx < obs.size()) begin
      chk_word($sformatf("word%0d_data", idx), obs[idx].d, d);
      chk($sformatf("word%0d_last", idx), 64'(obs[idx].l), 64'(l));
      chk($sformatf("word%0d_ws", idx), 64'(obs[idx].w), 64'(w));
    end
  endtask

  initial begin
    int idx;
    rst_n = 0; s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tlast = 0;
    weight_switch_req = 0; m_axis_tready = 1;
    @(posedge clk); #1;
    model_reset();
    do_reset();
    chk("reset_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("reset_frame_cnt", 64'(frame_cnt), 64'(0));

    // Continuous stream 1..6
    obs.delete();
    for (int i = 1; i <= 6; i++) send_beat(IN_W'(i), i == 6, 0);
    idle(3);
    chk("cont_words", 64'(obs.size()), 64'(2));
    chk_obs(0, w3(1, 2, 3), 0, 0);
    chk_obs(1, w3(4, 5, 6), 1, 0);
    chk("cont_frame_cnt", 64'(frame_cnt), 64'(1));

    // Backpressure: 10 stalled cycles while 9 beats are offered
    do_reset();
    obs.delete();
    m_axis_tready = 0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      s_axis_tvalid = 1; s_axis_tdata = IN_W'(idx + 1); s_axis_tlast = (idx == 8);
      tick();
      if (acc_flag) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'(5));
    chk("bp_tready", 64'(s_axis_tready), 64'(0));
    m_axis_tready = 1;
    for (int c = 0; c < 50 && idx < 9; c++) begin
      s_axis_tvalid = 1; s_axis_tdata = IN_W'(idx + 1); s_axis_tlast = (idx == 8);
      tick();
      if (acc_flag) idx++;
    end
    idle(4);
    chk("bp_words", 64'(obs.size()), 64'(3));
    chk_obs(0, w3(1, 2, 3), 0, 0);
    chk_obs(1, w3(4, 5, 6), 0, 0);
    chk_obs(2, w3(7, 8, 9), 1, 0);

    // Short frame A,B,C,D
    do_reset();
    obs.delete();
    send_beat(IN_W'('hA), 0, 0);
    send_beat(IN_W'('hB), 0, 0);
    send_beat(IN_W'('hC), 0, 0);
    send_beat(IN_W'('hD), 1, 0);
    idle(3);
    chk("short_words", 64'(obs.size()), 64'(2));
    chk_obs(0, w3('hA, 'hB, 'hC), 0, 0);
    chk_obs(1, w3('hD, 0, 0), 1, 0);
    chk("short_err", 64'(err_partial), 64'(1));
    for (int i = 1; i <= 3; i++) send_beat(IN_W'('hE0 + i), i == 3, 0);
    idle(3);
    chk("short_err_sticky", 64'(err_partial), 64'(1));

    // Reset mid-word
    obs.delete();
    send_beat(IN_W'('h51), 0, 0);
    send_beat(IN_W'('h52), 0, 0);
    do_reset();
    chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("rst_err", 64'(err_partial), 64'(0));
    send_beat(IN_W'('h58), 0, 0);
    send_beat(IN_W'('h59), 0, 0);
    send_beat(IN_W'('h5A), 1, 0);
    idle(3);
    chk("rst_words", 64'(obs.size()), 64'(1));
    chk_obs(0, w3('h58, 'h59, 'h5A), 1, 0);

    // Weight switch across three frames
    do_reset();
    obs.delete();
    for (int i = 1; i <= 15; i++)
      send_beat(IN_W'(i), i == 6 || i == 12 || i == 15, i == 5 || i == 9);
    idle(3);
    chk("ws_words", 64'(obs.size()), 64'(5));
    chk_obs(0, w3(1, 2, 3), 0, 0);
    chk_obs(1, w3(4, 5, 6), 1, 0);
    chk_obs(2, w3(7, 8, 9), 0, 1);
    chk_obs(3, w3(10, 11, 12), 1, 0);
    chk_obs(4, w3(13, 14, 15), 1, 1);

    // frame_cnt wrap over 17 single-word frames
    do_reset();
    for (int f = 0; f < 17; f++) begin
      for (int b = 0; b < 3; b++) send_beat(IN_W'(f * 3 + b), b == 2, 0);
      idle(2);
      chk($sformatf("wrap_cnt_f%0d", f), 64'(frame_cnt), 64'((f + 1) % 16));
    end

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (!s_axis_tvalid || acc_flag) begin
        s_axis_tvalid = ($urandom_range(3) != 0);
        for (int k = 0; k < IN_W / 32; k++) s_axis_tdata[32*k +: 32] = $urandom();
        s_axis_tlast = ($urandom_range(4) == 0);
      end
      weight_switch_req = ($urandom_range(15) == 0);
      m_axis_tready = ($urandom_range(2) != 0);
      tick();
    end
    m_axis_tready = 1;
    idle(6);
    chk("drain_tvalid", 64'(m_axis_tvalid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
